jpu_fetch: RTL

//  Instruction fetch stage feeding mips_decode. Owns the PC, issues word fetches to instruction

---
 rtl/jpu_fetch_pkg.sv | 13 +
 rtl/jpu_fetch_fifo.sv | 39 +++
 rtl/jpu_fetch.sv | 99 +++++++++
 3 files changed

// File: rtl/jpu_fetch_pkg.sv
// jpu_fetch_pkg: fetch FSM encodings, reset vector, MIPS field positions and queue entry layout
package jpu_fetch_pkg;
  typedef enum logic {FETCH_RUN = 1'b0, FETCH_FLUSH = 1'b1} fetch_state_e;
  localparam logic [31:0] JPU_RESET_PC = 32'hBFC0_0000;
  localparam int OP_HI = 31, OP_LO = 26;
  localparam int FUNCT_HI = 5, FUNCT_LO = 0;
  localparam int RT_HI = 20, RT_LO = 16;
  typedef struct packed {
    logic        exc;
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/jpu_fetch_fifo.sv
// jpu_fetch_fifo: in-order {exc,pc,inst} queue with registered storage, flush and fill count
module jpu_fetch_fifo import jpu_fetch_pkg::*; #(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  fetch_entry_t  i_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output fetch_entry_t  o_data,
  output logic [CW-1:0] o_count
);
  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (i_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;
endmodule

// File: rtl/jpu_fetch.sv
// jpu_fetch: PC owner, credit-limited imem fetch, in-order queue to decode, redirect flush.
// JPU_FETCH_ALIGN_CHECK_EN turns misaligned redirects into a single address-error entry.
module jpu_fetch import jpu_fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC   = JPU_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dcd_valid,
  input  logic        dcd_ready,
  output logic [31:0] dcd_inst,
  output logic [31:0] dcd_pc,
  output logic [5:0]  dcd_op,
  output logic [5:0]  dcd_funct2,
  output logic [4:0]  dcd_rt,
  output logic        dcd_fetch_exc
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_e  r_state;
  logic [31:0]   r_pc, r_rsp_pc, r_req_addr;
  logic          r_req_valid, r_stale, r_halt, r_exc_pend;
  logic [CW-1:0] r_out, r_drop, w_count, w_out_n, w_drop_n, w_used;
  logic          w_acc, w_rsp, w_rsp_keep, w_pop, w_push, w_exc_push, w_issue, w_misal;
  logic [31:0]   w_rpc;
  fetch_entry_t  w_entry, w_head;
`ifdef JPU_FETCH_ALIGN_CHECK_EN
  assign w_rpc   = redirect_pc;
  assign w_misal = redirect_pc[1:0] != 2'b00;
`else
  assign w_rpc   = redirect_pc & 32'hFFFF_FFFC;
  assign w_misal = 1'b0;
`endif
  // responses with nothing outstanding (e.g. just after reset) are stray and ignored
  assign w_acc      = r_req_valid & imem_req_ready;
  assign w_rsp      = imem_rsp_valid & (r_out != '0);
  assign w_rsp_keep = w_rsp & !redirect_valid & (r_drop == '0);
  assign w_pop      = dcd_valid & dcd_ready & !redirect_valid;
  assign w_exc_push = r_exc_pend & !redirect_valid & (r_out == '0) & !r_req_valid;
  assign w_push     = w_rsp_keep | w_exc_push;
  assign w_entry    = '{exc: w_exc_push, pc: r_rsp_pc, inst: w_exc_push ? 32'h0 : imem_rsp_data};
  assign w_out_n    = r_out + CW'(w_acc) - CW'(w_rsp);
  assign w_drop_n   = redirect_valid ? w_out_n
                    : r_drop - CW'(w_rsp && r_drop != '0) + CW'(w_acc && r_stale);
  // queued + in flight + presented request must leave room for one more
  assign w_used     = w_count + r_out + CW'(r_req_valid) - CW'(w_pop);
  assign w_issue    = (r_state == FETCH_RUN) & !redirect_valid & !r_halt &
                      (!r_req_valid | w_acc) & (w_used < CW'(FIFO_DEPTH));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state     <= FETCH_RUN;
      r_pc        <= RESET_PC;
      r_rsp_pc    <= RESET_PC;
      r_req_valid <= 1'b0;
      r_req_addr  <= RESET_PC;
      r_out       <= '0;
      r_drop      <= '0;
      r_stale     <= 1'b0;
      r_halt      <= 1'b0;
      r_exc_pend  <= 1'b0;
    end else begin
      r_state     <= (redirect_valid ? (w_out_n != '0 || r_state == FETCH_FLUSH)
                                     : (r_state == FETCH_FLUSH && w_drop_n != '0)) ? FETCH_FLUSH : FETCH_RUN;
      r_out       <= w_out_n;
      r_drop      <= w_drop_n;
      r_req_valid <= w_issue | (r_req_valid & !w_acc);
      if (w_issue) r_req_addr <= r_pc;
      r_stale     <= redirect_valid ? (r_req_valid & !w_acc) : (r_stale & !w_acc);
      r_pc        <= redirect_valid ? w_rpc : w_issue ? r_pc + 32'd4 : r_pc;
      r_rsp_pc    <= redirect_valid ? w_rpc : w_rsp_keep ? r_rsp_pc + 32'd4 : r_rsp_pc;
      r_halt      <= redirect_valid ? w_misal : r_halt;
      r_exc_pend  <= redirect_valid ? w_misal : r_exc_pend & !w_exc_push;
    end
  jpu_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_data  (w_head),
    .o_count (w_count)
  );
  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = r_req_addr;
  assign dcd_valid      = w_count != '0;
  assign dcd_inst       = w_head.inst;
  assign dcd_pc         = w_head.pc;
  assign dcd_op         = w_head.inst[OP_HI:OP_LO];
  assign dcd_funct2     = w_head.inst[FUNCT_HI:FUNCT_LO];
  assign dcd_rt         = w_head.inst[RT_HI:RT_LO];
  assign dcd_fetch_exc  = w_head.exc;
endmodule
